// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-FSM state encoding, default geometry and the
// pointer increment helper used by both the RP and WP side controllers.
package fifo_pkg;

    localparam int FIFO_PTR_W  = 8;
    localparam int FIFO_DEPTH  = 256;
    localparam int FIFO_DATA_W = 64;
    localparam int FIFO_RD_LAT = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } rd_state_t;

    // Wraps at the configured depth, which may be smaller than 2^PTR_W.
    function automatic logic [31:0] ptr_inc_wrap(input logic [31:0] ptr,
                                                 input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_occ_cnt.sv
// FIFO occupancy counter with registered empty/full flags.
// almost_full is only present when FIFO_RD_ALMOST_FULL_EN is defined.
module fifo_occ_cnt
    import fifo_pkg::*;
#(
    parameter int PTR_W = FIFO_PTR_W,
    parameter int DEPTH = FIFO_DEPTH
`ifdef FIFO_RD_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = DEPTH - 4
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           dec,
    output logic [PTR_W:0] count,
    output logic           empty,
    output logic           full
`ifdef FIFO_RD_ALMOST_FULL_EN
    ,
    output logic           almost_full
`endif
);

    localparam logic [PTR_W:0] CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W + 1)'(DEPTH);
`ifdef FIFO_RD_ALMOST_FULL_EN
    localparam logic [PTR_W:0] CNT_AF    = (PTR_W + 1)'(AF_THRESH);
`endif

    logic [PTR_W:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (inc && !dec) begin
            count_nxt = count + CNT_ONE;
        end else if (dec && !inc) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Flags are derived from the next count so they line up with count itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
`ifdef FIFO_RD_ALMOST_FULL_EN
            almost_full <= 1'b0;
`endif
        end else begin
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == CNT_DEPTH);
`ifdef FIFO_RD_ALMOST_FULL_EN
            almost_full <= (count_nxt >= CNT_AF);
`endif
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: tracks occupancy, advances RP and captures RAM data
// into a valid/ready output stage. FIFO_RD_ALMOST_FULL_EN adds almost_full.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_W  = FIFO_PTR_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int DATA_W = FIFO_DATA_W,
    parameter int RD_LAT = FIFO_RD_LAT
`ifdef FIFO_RD_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = DEPTH - 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  RP,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              rd_ready,
    output logic              RP_en,
    output logic [PTR_W-1:0]  RP_next,
    output logic              FIFO_EMPTY,
    output logic              FIFO_FULL,
    output logic [PTR_W:0]    count,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
`ifdef FIFO_RD_ALMOST_FULL_EN
    ,
    output logic              almost_full
`endif
);

    // state   | meaning
    // S_IDLE  | output stage empty, waiting for the FIFO to hold a word
    // S_FETCH | read committed, waiting RD_LAT cycles for ram_dout
    // S_VALID | rd_data held for the consumer until rd_ready

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    rd_state_t  state, state_nxt;
    logic [1:0] lat_cnt, lat_cnt_nxt;
    logic       capture;
    logic       inc;

    assign RP_next = PTR_W'(ptr_inc_wrap(32'(RP), 32'(DEPTH)));
    assign inc     = wr_en & ~FIFO_FULL;

    fifo_occ_cnt #(
        .PTR_W     (PTR_W),
        .DEPTH     (DEPTH)
`ifdef FIFO_RD_ALMOST_FULL_EN
        ,
        .AF_THRESH (AF_THRESH)
`endif
    ) u_occ (
        .clk         (clk),
        .rst         (rst),
        .inc         (inc),
        .dec         (RP_en),
        .count       (count),
        .empty       (FIFO_EMPTY),
        .full        (FIFO_FULL)
`ifdef FIFO_RD_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            lat_cnt <= 2'd0;
            rd_data <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            if (capture) begin
                rd_data <= ram_dout;
            end
        end
    end

    // RP_en doubles as the occupancy decrement, so it is gated by FIFO_EMPTY.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        RP_en       = 1'b0;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!FIFO_EMPTY) begin
                    RP_en       = 1'b1;
                    lat_cnt_nxt = 2'd0;
                    state_nxt   = S_FETCH;
                end
            end
            S_FETCH: begin
                lat_cnt_nxt = lat_cnt + 2'd1;
                if (lat_cnt == LAT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (rd_ready) begin
                    if (!FIFO_EMPTY) begin
                        RP_en       = 1'b1;
                        lat_cnt_nxt = 2'd0;
                        state_nxt   = S_FETCH;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign rd_valid = (state == S_VALID);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: RP_next wrap table, a cycle-vector table for a
// single read, and hand-written back-pressure, full, reset and simultaneity sequences.
module tb_fifo_rd_ctrl;

    localparam int PTR_W  = 8;
    localparam int DEPTH  = 256;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_ready = 1'b0;
    logic [PTR_W-1:0]  RP;
    logic [DATA_W-1:0] ram_dout = '0;
    logic              RP_en;
    logic [PTR_W-1:0]  RP_next;
    logic              FIFO_EMPTY;
    logic              FIFO_FULL;
    logic [PTR_W:0]    count;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    // second instance with a non-power-of-two depth, only its RP_next is checked
    logic              s_rp_en;
    logic [PTR_W-1:0]  s_rp_next;
    logic              s_empty, s_full, s_valid;
    logic [PTR_W:0]    s_count;
    logic [DATA_W-1:0] s_data;

`ifdef FIFO_RD_ALMOST_FULL_EN
    logic              almost_full;
    logic              s_almost_full;
`endif

    logic [PTR_W-1:0]  rp_reg;
    logic              rp_force = 1'b0;
    logic [PTR_W-1:0]  rp_force_val = '0;

    int n_cmp = 0;
    int n_err = 0;
    int rpen_pulses = 0;
    int valid_cycles = 0;

    always #5 clk = ~clk;

    assign RP = rp_force ? rp_force_val : rp_reg;

    fifo_rd_ctrl #(.PTR_W(PTR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .RD_LAT(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .RP         (RP),
        .ram_dout   (ram_dout),
        .rd_ready   (rd_ready),
        .RP_en      (RP_en),
        .RP_next    (RP_next),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_FULL  (FIFO_FULL),
        .count      (count),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
`ifdef FIFO_RD_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    fifo_rd_ctrl #(.PTR_W(PTR_W), .DEPTH(200), .DATA_W(DATA_W), .RD_LAT(1)) u_dut_d200 (
        .clk        (clk),
        .rst        (1'b1),
        .wr_en      (1'b0),
        .RP         (RP),
        .ram_dout   (ram_dout),
        .rd_ready   (1'b0),
        .RP_en      (s_rp_en),
        .RP_next    (s_rp_next),
        .FIFO_EMPTY (s_empty),
        .FIFO_FULL  (s_full),
        .count      (s_count),
        .rd_valid   (s_valid),
        .rd_data    (s_data)
`ifdef FIFO_RD_ALMOST_FULL_EN
        ,
        .almost_full (s_almost_full)
`endif
    );

    function automatic logic [63:0] word_of(input logic [7:0] a);
        return 64'h00A5 | ({56'h0, a} << 16);
    endfunction

    // RP register and synchronous RAM models
    always @(posedge clk or posedge rst) begin
        if (rst) rp_reg <= '0;
        else if (RP_en) rp_reg <= RP_next;
    end

    always @(posedge clk) begin
        ram_dout <= word_of(RP);
        if (RP_en) rpen_pulses <= rpen_pulses + 1;
        if (rd_valid) valid_cycles <= valid_cycles + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic wr, input logic rdy);
        @(negedge clk);
        wr_en    = wr;
        rd_ready = rdy;
        #1;
    endtask

    typedef struct {
        logic [7:0] rp;
        logic [7:0] nxt256;
        logic [7:0] nxt200;
        logic       chk200;
    } wrap_vec_t;

    typedef struct {
        logic        wr;
        logic        rdy;
        logic [8:0]  cnt;
        logic        emp;
        logic        rpen;
        logic [7:0]  nxt;
        logic        vld;
        logic [63:0] dat;
    } cyc_vec_t;

    wrap_vec_t wvec[7];
    cyc_vec_t  cvec[5];

    initial begin
        int base_rpen;
        int base_valid;

        wvec[0] = '{8'd0,   8'd1,   8'd1,   1'b1};
        wvec[1] = '{8'd1,   8'd2,   8'd2,   1'b1};
        wvec[2] = '{8'd127, 8'd128, 8'd128, 1'b1};
        wvec[3] = '{8'd198, 8'd199, 8'd199, 1'b1};
        wvec[4] = '{8'd199, 8'd200, 8'd0,   1'b1};
        wvec[5] = '{8'd254, 8'd255, 8'd0,   1'b0};
        wvec[6] = '{8'd255, 8'd0,   8'd0,   1'b0};

        //            wr    rdy   cnt   emp   rpen  nxt   vld   dat
        cvec[0] = '{1'b1, 1'b0, 9'd0, 1'b1, 1'b0, 8'd1, 1'b0, 64'h0};
        cvec[1] = '{1'b0, 1'b0, 9'd1, 1'b0, 1'b1, 8'd1, 1'b0, 64'h0};
        cvec[2] = '{1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 8'd2, 1'b0, 64'h0};
        cvec[3] = '{1'b0, 1'b1, 9'd0, 1'b1, 1'b0, 8'd2, 1'b1, 64'hA5};
        cvec[4] = '{1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 8'd2, 1'b0, 64'h0};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(FIFO_EMPTY), 64'd1);
        check("rst_full", 64'(FIFO_FULL), 64'd0);
        check("rst_rp_en", 64'(RP_en), 64'd0);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_data", rd_data, 64'd0);

        rp_force = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rp_force_val = wvec[i].rp;
            #1;
            check($sformatf("rp_next_d256[%0d]", wvec[i].rp), 64'(RP_next), 64'(wvec[i].nxt256));
            if (wvec[i].chk200)
                check($sformatf("rp_next_d200[%0d]", wvec[i].rp), 64'(s_rp_next), 64'(wvec[i].nxt200));
        end
        rp_force = 1'b0;

        @(negedge clk);
        rst = 1'b0;

        // single word read
        for (int i = 0; i < 5; i++) begin
            cyc(cvec[i].wr, cvec[i].rdy);
            check($sformatf("v%0d_count", i), 64'(count), 64'(cvec[i].cnt));
            check($sformatf("v%0d_empty", i), 64'(FIFO_EMPTY), 64'(cvec[i].emp));
            check($sformatf("v%0d_full", i), 64'(FIFO_FULL), 64'd0);
            check($sformatf("v%0d_rp_en", i), 64'(RP_en), 64'(cvec[i].rpen));
            check($sformatf("v%0d_rp_next", i), 64'(RP_next), 64'(cvec[i].nxt));
            check($sformatf("v%0d_valid", i), 64'(rd_valid), 64'(cvec[i].vld));
            if (cvec[i].vld) check($sformatf("v%0d_data", i), rd_data, cvec[i].dat);
        end

        // back-pressure: three writes, consumer stalls for five cycles
        base_rpen = rpen_pulses;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check("bp_first_rp_en", 64'(RP_en), 64'd1);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0);
            check($sformatf("bp_hold%0d_valid", i), 64'(rd_valid), 64'd1);
            check($sformatf("bp_hold%0d_data", i), rd_data, word_of(8'd1));
            check($sformatf("bp_hold%0d_count", i), 64'(count), 64'd2);
            check($sformatf("bp_hold%0d_rp_en", i), 64'(RP_en), 64'd0);
        end
        check("bp_rp_en_pulses", 64'(rpen_pulses - base_rpen), 64'd1);
        cyc(1'b0, 1'b1);
        check("bp_release_rp_en", 64'(RP_en), 64'd1);
        check("bp_release_rp_next", 64'(RP_next), 64'd3);
        cyc(1'b0, 1'b0);
        check("bp_refetch_valid", 64'(rd_valid), 64'd0);
        check("bp_refetch_count", 64'(count), 64'd1);
        cyc(1'b0, 1'b1);
        check("bp_w2_data", rd_data, word_of(8'd2));
        check("bp_w2_rp_en", 64'(RP_en), 64'd1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check("bp_w3_data", rd_data, word_of(8'd3));
        check("bp_w3_rp_en", 64'(RP_en), 64'd0);
        cyc(1'b0, 1'b0);
        check("bp_done_valid", 64'(rd_valid), 64'd0);
        check("bp_done_empty", 64'(FIFO_EMPTY), 64'd1);

        // fill to full while the output stage holds one word
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("full_hold_data", rd_data, word_of(8'd4));
        for (int i = 0; i < 257; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 255) begin
                check("full_255_count", 64'(count), 64'd255);
                check("full_255_full", 64'(FIFO_FULL), 64'd0);
            end
            if (i == 256) begin
                check("full_256_count", 64'(count), 64'd256);
                check("full_256_full", 64'(FIFO_FULL), 64'd1);
            end
        end
        cyc(1'b0, 1'b1);
        check("ovf_count", 64'(count), 64'd256);
        check("ovf_full", 64'(FIFO_FULL), 64'd1);
        check("ovf_rp_en", 64'(RP_en), 64'd1);
        cyc(1'b0, 1'b0);
        check("fetch_count", 64'(count), 64'd255);
        check("fetch_full", 64'(FIFO_FULL), 64'd0);

        // asynchronous reset in the middle of the fetch
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_empty", 64'(FIFO_EMPTY), 64'd1);
        check("async_rst_full", 64'(FIFO_FULL), 64'd0);
        check("async_rst_rp_en", 64'(RP_en), 64'd0);
        check("async_rst_valid", 64'(rd_valid), 64'd0);
        check("async_rst_data", rd_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base_rpen  = rpen_pulses;
        base_valid = valid_cycles;
        repeat (6) cyc(1'b0, 1'b0);
        check("idle_count", 64'(count), 64'd0);
        check("idle_empty", 64'(FIFO_EMPTY), 64'd1);
        check("idle_rp_en_pulses", 64'(rpen_pulses - base_rpen), 64'd0);
        check("idle_valid_cycles", 64'(valid_cycles - base_valid), 64'd0);

        // write and RP_en together at count 1
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check("sim_rp_en", 64'(RP_en), 64'd1);
        check("sim_pre_count", 64'(count), 64'd1);
        cyc(1'b0, 1'b0);
        check("sim_count", 64'(count), 64'd1);
        check("sim_empty", 64'(FIFO_EMPTY), 64'd0);
        cyc(1'b0, 1'b1);
        check("sim_data", rd_data, word_of(8'd0));
        check("sim_next_rp_en", 64'(RP_en), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
